// File: rtl/rr_sched_pkg.sv
// Shared constants and state encoding for the round-robin grant scheduler.
package rr_sched_pkg;
  localparam int NREQ         = 8;
  localparam int IDX_W        = 3;
  localparam int HOLD_MAX_DEF = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;
endpackage

// File: rtl/idx_onehot_dec.sv
// Combinational index-to-one-hot decoder; all-zero output when not enabled.
module idx_onehot_dec
  import rr_sched_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [NREQ-1:0]  onehot
);
  // One bit set at idx when enabled, otherwise no bits set
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/rr_grant_sched8.sv
// Round-robin scheduler: 8 requesters share one resource, one-hot registered grant.
// Optional hold limit enabled by macro GRANT_TIMEOUT_EN.
// The owner-finished input is named owner_release because "release" is a
// reserved word in SystemVerilog.
module rr_grant_sched8
  import rr_sched_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             owner_release,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  // First set request bit after ptr, wrapping; ptr itself is searched last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] i;
    rr_pick = p;
    for (int off = NREQ; off >= 1; off--) begin
      i = p + IDX_W'(off);
      if (r[i]) rr_pick = i;
    end
  endfunction

  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n, idx_n;
  logic             vld_n, to_n, end_ab, hit;
  logic [NREQ-1:0]  grant_n;

`ifdef GRANT_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt, cnt_n;
`endif

  // Next-state, next-owner and timeout decision
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = grant_idx;
    vld_n   = grant_valid;
    to_n    = 1'b0;
    end_ab  = owner_release | ~req[grant_idx];
`ifdef GRANT_TIMEOUT_EN
    cnt_n   = hold_cnt;
    hit     = grant_valid && (hold_cnt == CNT_W'(HOLD_MAX));
`else
    hit     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          idx_n   = rr_pick(req, ptr);
          ptr_n   = idx_n;
          vld_n   = 1'b1;
          state_n = GRANT;
`ifdef GRANT_TIMEOUT_EN
          cnt_n   = CNT_W'(1);
`endif
        end
      end
      GRANT: begin
        if (end_ab || hit) begin
          vld_n   = 1'b0;
          state_n = GAP;
          // Timeout only flagged when the hold limit is the sole cause
          to_n    = hit & ~end_ab;
        end
`ifdef GRANT_TIMEOUT_EN
        else if (hold_cnt != '1) begin
          cnt_n = hold_cnt + CNT_W'(1);
        end
`endif
      end
      GAP:     state_n = IDLE;
      default: begin
        state_n = IDLE;
        vld_n   = 1'b0;
      end
    endcase
  end

  idx_onehot_dec u_dec (
    .idx    (idx_n),
    .en     (vld_n),
    .onehot (grant_n)
  );

  // State, pointer and registered grant outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= IDX_W'(NREQ - 1);
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      grant       <= grant_n;
      grant_idx   <= idx_n;
      grant_valid <= vld_n;
      timeout     <= to_n;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  // Hold counter, counts cycles of the current grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_cnt <= '0;
    else     hold_cnt <= cnt_n;
  end
`endif

endmodule
